fft_frame_feeder: RTL and testbench

Parametrised successor to the audio FIFO-to-FFT loader. The block arms the audio path to fill the sample FIFO and waits for a full frame aligned to a selectable codec channel. It then streams exactly FFT_POINTS words into the FFT core with full Avalon-ST backpressure, and tracks the FFT result packet to completion. It sits between the audio2fifo/FIFO pair and the FFT core, and adds single-shot/continuous modes, channel select, underrun detection and frame statistics.

---
 rtl/fft_frame_feeder_if.sv | 28 ++
 rtl/fft_frame_feeder.sv | 127 ++++++++++++
 tb/tb_fft_frame_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_if.sv
// FIFO / FFT-core handshake bundle seen by the frame feeder.
// master = feeder side, slave = FIFO, audio2fifo and FFT core side.
interface fft_frame_feeder_if;
  logic start2fill;
  logic fifo_wrempty;
  logic fifo_wrfull;
  logic fifo_rdempty;
  logic fifo_rdreq;
  logic sink_ready;
  logic sink_valid;
  logic sink_sop;
  logic sink_eop;
  logic source_valid;
  logic source_sop;
  logic source_eop;

  modport master (
    output start2fill, fifo_rdreq, sink_valid, sink_sop, sink_eop,
    input  fifo_wrempty, fifo_wrfull, fifo_rdempty, sink_ready,
    input  source_valid, source_sop, source_eop
  );

  modport slave (
    input  start2fill, fifo_rdreq, sink_valid, sink_sop, sink_eop,
    output fifo_wrempty, fifo_wrfull, fifo_rdempty, sink_ready,
    output source_valid, source_sop, source_eop
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Arms the audio FIFO fill, aligns the frame start to a codec channel,
// streams FFT_POINTS words into the FFT sink with backpressure and tracks
// the FFT result packet to completion. Control signals only; sample data
// flows from the FIFO to the FFT core outside this block.
module fft_frame_feeder #(
  parameter int FFT_POINTS = 1024,
  parameter int CNT_W      = 16,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              continuous,
  input  logic              ch_sel,
  input  logic              adclrc,
  fft_frame_feeder_if.master bus,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun,
  output logic [FCNT_W-1:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, ARM, FILL, SYNC, SEND, WAIT_RES, DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FFT_POINTS - 1);

  state_t              state_q, state_d;
  logic                adclrc_meta_q, adclrc_s_q;
  logic                ch_q;
  logic [CNT_W-1:0]    wordcnt_q, wordcnt_d;
  logic                underrun_q;
  logic [FCNT_W-1:0]   frame_cnt_q;
  logic                frame_done_q;
  logic                start2fill_q;

  logic                beat;      // accepted sink beat
  logic                done_evt;  // result packet completes this cycle
  logic                arm_evt;   // entering ARM this cycle
  logic                in_send;

  assign in_send  = (state_q == SEND);
  assign beat     = bus.sink_valid & bus.sink_ready;
  // A one-beat result packet (sop and eop together) completes straight from WAIT_RES.
  assign done_evt = bus.source_valid & bus.source_eop &
                    ((state_q == DRAIN) | ((state_q == WAIT_RES) & bus.source_sop));
  assign arm_evt  = (state_d == ARM) & (state_q != ARM);

  // Two-flop synchroniser for the codec LR clock, which is asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adclrc_meta_q <= 1'b0;
      adclrc_s_q    <= 1'b0;
    end else begin
      adclrc_meta_q <= adclrc;
      adclrc_s_q    <= adclrc_meta_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; once the frame is streaming, enable is ignored until completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable) state_d = ARM;
      ARM:      if (!enable) state_d = IDLE;
                else if (!bus.fifo_wrempty) state_d = FILL;
      FILL:     if (!enable) state_d = IDLE;
                else if (bus.fifo_wrfull) state_d = SYNC;
      SYNC:     if (!enable) state_d = IDLE;
                else if ((adclrc_s_q == ch_q) && bus.sink_ready) state_d = SEND;
      SEND:     if (beat && (wordcnt_q == LAST_WORD)) state_d = WAIT_RES;
      WAIT_RES: if (bus.source_valid && bus.source_sop) state_d = DRAIN;
      DRAIN:    ;
      default:  state_d = IDLE;
    endcase
    if (done_evt) state_d = (continuous && enable) ? ARM : IDLE;
  end

  // Sink-side handshake outputs, all gated to the SEND state.
  always_comb begin
    bus.sink_valid = in_send & ~bus.fifo_rdempty;
    bus.fifo_rdreq = bus.sink_valid & bus.sink_ready;
    bus.sink_sop   = bus.sink_valid & (wordcnt_q == '0);
    bus.sink_eop   = bus.sink_valid & (wordcnt_q == LAST_WORD);
    busy           = (state_q != IDLE);
  end

  // Word counter: cleared when SEND is entered, advanced on every accepted beat.
  always_comb begin
    wordcnt_d = wordcnt_q;
    if ((state_q == SYNC) && (state_d == SEND)) wordcnt_d = '0;
    else if (in_send && beat)                   wordcnt_d = wordcnt_q + CNT_W'(1);
  end

  // Datapath and status registers: counter, latched channel, fill request, stats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wordcnt_q    <= '0;
      ch_q         <= 1'b0;
      start2fill_q <= 1'b0;
      underrun_q   <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wordcnt_q    <= wordcnt_d;
      start2fill_q <= (state_d == ARM);
      frame_done_q <= done_evt;
      if (arm_evt) ch_q <= ch_sel;
      if (arm_evt)                          underrun_q <= 1'b0;
      else if (in_send && bus.fifo_rdempty) underrun_q <= 1'b1;
      if (done_evt) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign bus.start2fill = start2fill_q;
  assign frame_done     = frame_done_q;
  assign underrun       = underrun_q;
  assign frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with an 8-point frame and a 2-bit
// frame counter, driving the FIFO and FFT handshakes by hand.
module tb_fft_frame_feeder;
  localparam int NPTS = 8;
  localparam int CW   = 4;
  localparam int FW   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          continuous = 1'b0;
  logic          ch_sel = 1'b1;
  logic          adclrc = 1'b0;
  logic          busy, frame_done, underrun;
  logic [FW-1:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fc   = 0;

  fft_frame_feeder_if bus ();

  fft_frame_feeder #(.FFT_POINTS(NPTS), .CNT_W(CW), .FCNT_W(FW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .continuous  (continuous),
    .ch_sel      (ch_sel),
    .adclrc      (adclrc),
    .bus         (bus.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance to the drive point of the next cycle (2 time units after the edge).
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " start2fill"}, bus.start2fill, 0);
    check({tag, " sink_valid"}, bus.sink_valid, 0);
    check({tag, " sink_sop"}, bus.sink_sop, 0);
    check({tag, " sink_eop"}, bus.sink_eop, 0);
    check({tag, " rdreq"}, bus.fifo_rdreq, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " underrun"}, underrun, 0);
    check({tag, " frame_count"}, frame_count, 0);
  endtask

  // One complete frame. Beat-indexed controls: stall sink_ready, starve the FIFO,
  // drop enable, or assert reset; a value of -1 disables that event.
  task automatic do_frame(input string name, input bit ch,
                          input int stall_at, input int stall_len,
                          input int empty_at, input int empty_len,
                          input int drop_en_at, input int src_len, input int abort_at);
    int beats = 0;
    int rdreqs = 0;
    int send_cyc = 0;
    int waited = 0;
    int st_left = stall_len;
    int em_left = empty_len;
    bit started = 0;
    bit rdy, emp, v_exp, exp_busy;

    enable = 1; ch_sel = ch; adclrc = ~ch;
    bus.fifo_wrempty = 1; bus.fifo_wrfull = 0; bus.fifo_rdempty = 1; bus.sink_ready = 1;
    bus.source_valid = 0; bus.source_sop = 0; bus.source_eop = 0;

    // ARM: wait for the fill request
    #1;
    while (bus.start2fill !== 1'b1 && waited < 10) begin
      next_cycle(); #1; waited++;
    end
    check({name, " arm start2fill"}, bus.start2fill, 1);
    check({name, " arm underrun clear"}, underrun, 0);
    check({name, " arm busy"}, busy, 1);
    ch_sel = ~ch;                  // the latched channel must be the one that counts
    next_cycle(); #1;
    check({name, " arm hold"}, bus.start2fill, 1);
    next_cycle(); bus.fifo_wrempty = 0; #1;
    next_cycle(); #1;
    check({name, " fill start2fill"}, bus.start2fill, 0);
    check({name, " fill busy"}, busy, 1);
    next_cycle(); bus.fifo_wrfull = 1; bus.fifo_rdempty = 0; #1;
    check({name, " fill no valid"}, bus.sink_valid, 0);
    // SYNC with the wrong channel level: nothing may be sent
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      check({name, " sync wait valid"}, bus.sink_valid, 0);
      check({name, " sync wait rdreq"}, bus.fifo_rdreq, 0);
    end
    next_cycle(); adclrc = ch;

    for (int i = 0; i < 60 && beats < NPTS; i++) begin
      if (beats == abort_at) begin
        reset_n = 0; #1;
        check_all_zero({name, " async reset"});
        return;
      end
      rdy = 1; emp = 0;
      if (beats == stall_at && st_left > 0) begin rdy = 0; st_left--; end
      if (beats == empty_at && em_left > 0) begin emp = 1; em_left--; end
      if (beats == drop_en_at) enable = 0;
      bus.sink_ready = rdy; bus.fifo_rdempty = emp;
      #1;
      if (bus.sink_valid === 1'b1) started = 1;
      if (started) begin
        send_cyc++;
        v_exp = ~emp;
        check({name, " sink_valid"}, bus.sink_valid, v_exp);
        check({name, " sink_sop"}, bus.sink_sop, v_exp && beats == 0);
        check({name, " sink_eop"}, bus.sink_eop, v_exp && beats == NPTS - 1);
        check({name, " rdreq"}, bus.fifo_rdreq, v_exp && rdy);
        if (bus.fifo_rdreq === 1'b1) rdreqs++;
        if (v_exp && rdy) beats++;
      end
      next_cycle();
    end
    check({name, " accepted beats"}, beats, NPTS);
    check({name, " rdreq cycles"}, rdreqs, NPTS);
    check({name, " send cycles"}, send_cyc, NPTS + stall_len + empty_len);
    check({name, " underrun"}, underrun, empty_len > 0);

    // WAIT_RES / DRAIN
    ch_sel = ch; bus.fifo_rdempty = 1; bus.fifo_wrfull = 0; bus.fifo_wrempty = 1; bus.sink_ready = 1;
    #1;
    check({name, " wait_res busy"}, busy, 1);
    check({name, " wait_res no valid"}, bus.sink_valid, 0);
    next_cycle();
    for (int k = 0; k < src_len; k++) begin
      bus.source_valid = 1; bus.source_sop = (k == 0); bus.source_eop = (k == src_len - 1);
      #1;
      check({name, " done early"}, frame_done, 0);
      next_cycle();
    end
    bus.source_valid = 0; bus.source_sop = 0; bus.source_eop = 0;
    exp_busy = continuous & enable;
    if (!continuous) enable = 0;
    #1;
    exp_fc = (exp_fc + 1) % (1 << FW);
    check({name, " frame_done"}, frame_done, 1);
    check({name, " frame_count"}, frame_count, exp_fc);
    check({name, " underrun held"}, underrun, empty_len > 0);
    check({name, " busy after"}, busy, exp_busy);
    check({name, " rearm start2fill"}, bus.start2fill, exp_busy);
    next_cycle(); #1;
    check({name, " done pulse width"}, frame_done, 0);
    $display("frame %-14s ch=%0d beats=%0d send_cycles=%0d underrun=%0d frame_count=%0d",
             name, ch, beats, send_cyc, underrun, frame_count);
    next_cycle();
  endtask

  initial begin
    bus.fifo_wrempty = 1; bus.fifo_wrfull = 0; bus.fifo_rdempty = 1; bus.sink_ready = 1;
    bus.source_valid = 0; bus.source_sop = 0; bus.source_eop = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    next_cycle(); reset_n = 1;
    next_cycle();

    do_frame("basic",       1'b1, -1, 0, -1, 0, -1, NPTS, -1);
    do_frame("ready_stall", 1'b1,  3, 3, -1, 0, -1, NPTS, -1);
    do_frame("underrun_R",  1'b0, -1, 0,  5, 2, -1, 1,    -1);

    // enable dropped in FILL: back to IDLE, no sink activity
    enable = 1; ch_sel = 1; adclrc = 1;
    bus.fifo_wrempty = 1; bus.fifo_wrfull = 0; bus.fifo_rdempty = 1; bus.sink_ready = 1;
    next_cycle(); next_cycle(); #1;
    check("filldrop arm", bus.start2fill, 1);
    check("filldrop underrun cleared", underrun, 0);
    next_cycle(); bus.fifo_wrempty = 0; #1;
    next_cycle(); #1;
    check("filldrop in fill busy", busy, 1);
    check("filldrop in fill start2fill", bus.start2fill, 0);
    next_cycle(); enable = 0; #1;
    next_cycle(); #1;
    check("filldrop idle busy", busy, 0);
    bus.fifo_wrfull = 1; bus.fifo_rdempty = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); #1;
      check("filldrop no valid", bus.sink_valid, 0);
      check("filldrop no rdreq", bus.fifo_rdreq, 0);
      check("filldrop no start2fill", bus.start2fill, 0);
    end
    $display("filldrop enable=0 in FILL busy=%0d start2fill=%0d", busy, bus.start2fill);
    bus.fifo_wrfull = 0; bus.fifo_rdempty = 1; bus.fifo_wrempty = 1;
    next_cycle();

    // reset asserted at beat 4 of SEND
    do_frame("reset_abort", 1'b1, -1, 0, -1, 0, -1, NPTS, 4);
    enable = 0;
    next_cycle(); next_cycle();
    reset_n = 1; exp_fc = 0;
    next_cycle(); #1;
    check("post reset busy", busy, 0);
    check("post reset frame_count", frame_count, 0);
    check("post reset sink_valid", bus.sink_valid, 0);
    $display("reset_abort busy=%0d frame_count=%0d", busy, frame_count);
    next_cycle();

    // continuous mode, five frames; counter wraps modulo 4
    continuous = 1;
    for (int f = 0; f < 5; f++) begin
      if (f == 4) continuous = 0;
      do_frame("continuous", 1'b1, -1, 0, -1, 0, -1, NPTS, -1);
      if (f == 2) check("cont three frames count", frame_count, 3);
    end
    check("cont five frames count", frame_count, 1);

    // enable dropped mid-SEND: frame still completes, then IDLE
    do_frame("en_drop_send", 1'b1, -1, 0, -1, 0, 2, 4, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
